fir_coeff_update_ctrl: RTL

//  Sequences coefficient updates into the 5x5 systolic FIR datapath without tearing a frame.
//  A host streams a complete kernel image into an internal shadow buffer over a valid/ready port.
//  At the next vertical-sync leading edge, the block bursts the whole image to the filter's

---
 rtl/fir_coeff_update_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_coeff_update_ctrl.sv
// Coefficient update sequencer for the 5x5 systolic FIR.
// The host fills a shadow image over valid/ready. A full image is burst to the filter's
// coefficient port on the next vsync leading edge, so kernels only change between frames.
module fir_coeff_update_ctrl #(
  parameter int unsigned NUM_WORDS = 7,
  parameter int unsigned AW        = 3,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs_i,
  input  logic          wr_valid_i,
  input  logic [31:0]   wr_data_i,
  output logic          wr_ready_o,
  input  logic          abort_i,
  output logic [31:0]   coeff_data_o,
  output logic [AW-1:0] coeff_addr_o,
  output logic          coeff_we_o,
  output logic          pending_o,
  output logic          busy_o,
  output logic          update_done_o,
  output logic [7:0]    update_cnt_o
);

  typedef enum logic [1:0] {StLoad, StPend, StBurst, StDone} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_wcnt;
  logic [AW-1:0]   r_rcnt;
  logic            r_vs_q;
  logic [31:0]     r_shadow [NUM_WORDS];

  logic            r_wr_ready;
  logic [31:0]     r_coeff_data;
  logic [AW-1:0]   r_coeff_addr;
  logic            r_coeff_we;
  logic            r_pending;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_cnt;

  logic            w_vs_n;
  logic            w_vs_edge;
  logic            w_accept;
  logic            w_last_word;
  logic            w_last_read;
  logic [AW-1:0]   w_rnext;

  // Sync normalisation, edge detect and write-acceptance decode.
  always_comb begin
    w_vs_n      = (vs_i == VS_POL);
    w_vs_edge   = w_vs_n & ~r_vs_q;
    // Abort wins over a word offered in the same cycle.
    w_accept    = (r_state == StLoad) & wr_valid_i & r_wr_ready & ~abort_i;
    w_last_word = (r_wcnt == AW'(NUM_WORDS - 1));
    w_last_read = (r_rcnt == AW'(NUM_WORDS - 1));
    w_rnext     = r_rcnt + AW'(1);
  end

  // Shadow image storage; only overwritten, never cleared.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow[r_wcnt] <= wr_data_i;
    end
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StLoad;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      // Treat sync as already active so a frame in progress at release is not an edge.
      r_vs_q       <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_coeff_data <= '0;
      r_coeff_addr <= '0;
      r_coeff_we   <= 1'b0;
      r_pending    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_vs_q <= w_vs_n;
      r_done <= 1'b0;
      unique case (r_state)
        StLoad: begin
          r_wr_ready <= 1'b1;
          if (abort_i) begin
            r_wcnt <= '0;
          end else if (w_accept) begin
            if (w_last_word) begin
              // Any sync edge this same cycle is lost; commit waits for the next frame.
              r_wcnt     <= '0;
              r_state    <= StPend;
              r_wr_ready <= 1'b0;
              r_pending  <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + AW'(1);
            end
          end
        end
        StPend: begin
          if (abort_i) begin
            r_state    <= StLoad;
            r_wcnt     <= '0;
            r_pending  <= 1'b0;
            r_wr_ready <= 1'b1;
          end else if (w_vs_edge) begin
            r_state      <= StBurst;
            r_pending    <= 1'b0;
            r_busy       <= 1'b1;
            r_rcnt       <= '0;
            r_coeff_we   <= 1'b1;
            r_coeff_addr <= '0;
            r_coeff_data <= r_shadow[0];
          end
        end
        StBurst: begin
          // Atomic: abort and sync edges are not looked at here.
          if (w_last_read) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_coeff_we <= 1'b0;
            r_done     <= 1'b1;
            r_cnt      <= r_cnt + 8'd1;
          end else begin
            r_rcnt       <= w_rnext;
            r_coeff_addr <= w_rnext;
            r_coeff_data <= r_shadow[w_rnext];
          end
        end
        StDone: begin
          r_state    <= StLoad;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state <= StLoad;
        end
      endcase
    end
  end

  assign wr_ready_o    = r_wr_ready;
  assign coeff_data_o  = r_coeff_data;
  assign coeff_addr_o  = r_coeff_addr;
  assign coeff_we_o    = r_coeff_we;
  assign pending_o     = r_pending;
  assign busy_o        = r_busy;
  assign update_done_o = r_done;
  assign update_cnt_o  = r_cnt;

endmodule
